// File: rtl/sram_arb_pkg.sv
// Shared types and frame geometry for the image-SRAM arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int SRAM_ADDR_W = 18;
   localparam int PIX_W       = 8;
   localparam logic [SRAM_ADDR_W-1:0] FRAME_LAST_ADDR = 18'h3FFFF;

endpackage

// File: rtl/write_fifo.sv
// Write buffer with per-entry valid/address taps for read-after-write checks.
// Push/pop land on the next edge; no full pass-through, caller gates push with !full.
module write_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 18,
   parameter int DW    = 8
) (
   input  logic                     clk_i,
   input  logic                     n_rst_i,
   input  logic                     push_i,
   input  logic [AW-1:0]            push_addr_i,
   input  logic [DW-1:0]            push_data_i,
   input  logic                     pop_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [AW-1:0]            head_addr_o,
   output logic [DW-1:0]            head_data_o,
   output logic [DEPTH-1:0]         ent_vld_o,
   output logic [AW-1:0]            ent_addr_o [DEPTH]
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic [DEPTH-1:0] vld_q;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         if (push_i) begin
            vld_q[wptr_q] <= 1'b1;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop_i) begin
            vld_q[rptr_q] <= 1'b0;
            rptr_q        <= rptr_q + 1'b1;
         end
         if (push_i && !pop_i)
            count_q <= count_q + 1'b1;
         else if (pop_i && !push_i)
            count_q <= count_q - 1'b1;
      end
   end

   // Payload needs no reset: vld_q guards every consumer.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         addr_q[wptr_q] <= push_addr_i;
         data_q[wptr_q] <= push_data_i;
      end
   end

   assign full_o      = (count_q == CW'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign count_o     = count_q;
   assign head_addr_o = addr_q[rptr_q];
   assign head_data_o = data_q[rptr_q];
   assign ent_vld_o   = vld_q;
   assign ent_addr_o  = addr_q;

endmodule

// File: rtl/sram_access_arbiter.sv
// Single-port image SRAM shared by a pixel reader and a buffered edge-map writer.
// Grant is combinational, strobes one cycle later, read data two cycles after grant; writes stall on wr_ready.
module sram_access_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W        = SRAM_ADDR_W,
   parameter int DATA_W        = PIX_W,
   parameter int WBUF_DEPTH    = 4,
   parameter int RD_LAT        = 1,
   parameter int MAX_RD_STREAK = 8
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          rd_req,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic                          rd_grant,
   output logic                          rd_valid,
   output logic [DATA_W-1:0]             rd_data,
   input  logic                          wr_req,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ready,
   input  logic                          frame_end,
   output logic                          frame_done,
   output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
   output logic                          sram_read_enable,
   output logic                          sram_write_enable,
   output logic [ADDR_W-1:0]             sram_address,
   output logic [DATA_W-1:0]             sram_wdata,
   input  logic [DATA_W-1:0]             sram_rdata
);

   localparam int STRK_W = $clog2(MAX_RD_STREAK + 1);

   logic                  fifo_full, fifo_empty, push, pop;
   logic [ADDR_W-1:0]     head_addr;
   logic [DATA_W-1:0]     head_data;
   logic [WBUF_DEPTH-1:0] ent_vld;
   logic [ADDR_W-1:0]     ent_addr [WBUF_DEPTH];

   arb_state_t            state_q, state_d;
   logic                  out_en_q;
   logic [STRK_W-1:0]     streak_q, streak_d;
   logic [RD_LAT-1:0]     pend_q, pend_d;
   logic                  rd_valid_q;
   logic [DATA_W-1:0]     rd_data_q;
   logic                  sram_re_q, sram_we_q;
   logic [ADDR_W-1:0]     sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0]     sram_wdata_q, sram_wdata_d;
   logic                  addr_hit, hazard, flushing, active, force_wr;

   write_fifo #(.DEPTH(WBUF_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_wbuf (
      .clk_i       (clk),
      .n_rst_i     (n_rst),
      .push_i      (push),
      .push_addr_i (wr_addr),
      .push_data_i (wr_data),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (wbuf_count),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .ent_vld_o   (ent_vld),
      .ent_addr_o  (ent_addr)
   );

   // A write pushed in the same cycle counts as older than the read.
   always_comb begin
      addr_hit = push && (wr_addr == rd_addr);
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if (ent_vld[i] && (ent_addr[i] == rd_addr))
            addr_hit = 1'b1;
      end
      hazard = rd_req && addr_hit;
   end

   // out_en_q keeps the combinational handshakes low until the first edge after reset.
   assign wr_ready = out_en_q && !fifo_full;
   assign push     = wr_req && wr_ready;
   assign flushing = frame_end || (state_q == FLUSH);
   assign active   = out_en_q && (state_q != DONE);
   assign force_wr = !fifo_empty &&
                     (fifo_full || hazard || (streak_q == STRK_W'(MAX_RD_STREAK)));
   assign rd_grant = active && rd_req && !flushing && !hazard && !force_wr;
   assign pop      = active && !fifo_empty && !rd_grant;

   always_comb begin
      streak_d = streak_q;
      if (pop)
         streak_d = '0;
      else if (rd_grant)
         streak_d = fifo_empty ? '0 : streak_q + 1'b1;

      pend_d[0] = rd_grant;
      for (int i = 1; i < RD_LAT; i++)
         pend_d[i] = pend_q[i-1];

      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      if (rd_grant) begin
         sram_addr_d = rd_addr;
      end else if (pop) begin
         sram_addr_d  = head_addr;
         sram_wdata_d = head_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (frame_end) state_d = FLUSH;
                else if (rd_req || wr_req || !fifo_empty) state_d = RUN;
         RUN:   if (frame_end) state_d = FLUSH;
                else if (!rd_req && !wr_req && fifo_empty) state_d = IDLE;
         FLUSH: if (fifo_empty && !push && (pend_q == '0)) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         out_en_q     <= 1'b0;
         streak_q     <= '0;
         pend_q       <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         sram_re_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         out_en_q     <= 1'b1;
         streak_q     <= streak_d;
         pend_q       <= pend_d;
         rd_valid_q   <= pend_q[RD_LAT-1];
         if (pend_q[RD_LAT-1])
            rd_data_q <= sram_rdata;
         sram_re_q    <= rd_grant;
         sram_we_q    <= pop;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
      end
   end

   assign rd_valid          = rd_valid_q;
   assign rd_data           = rd_data_q;
   assign frame_done        = (state_q == DONE);
   assign sram_read_enable  = sram_re_q;
   assign sram_write_enable = sram_we_q;
   assign sram_address      = sram_addr_q;
   assign sram_wdata        = sram_wdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with an SRAM model and read/write scoreboards.
module tb_sram_access_arbiter;
   import sram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        rd_req, wr_req, frame_end;
   logic [17:0] rd_addr, wr_addr;
   logic [7:0]  wr_data;
   logic        rd_grant, rd_valid, wr_ready, frame_done;
   logic [7:0]  rd_data;
   logic [2:0]  wbuf_count;
   logic        sram_read_enable, sram_write_enable;
   logic [17:0] sram_address;
   logic [7:0]  sram_wdata;
   logic [7:0]  sram_rdata = 8'h00;
   logic [42:0] outs;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_we_cyc = -1;
   int fd_cnt = 0;
   int fd_cyc = -1;
   int valid_cnt = 0;

   logic [7:0]  sram_mem [int];
   logic [7:0]  ref_mem  [int];
   logic [7:0]  exp_rd [$];
   int          exp_rt [$];
   logic [25:0] exp_wr [$];

   sram_access_arbiter dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .rd_req            (rd_req),
      .rd_addr           (rd_addr),
      .rd_grant          (rd_grant),
      .rd_valid          (rd_valid),
      .rd_data           (rd_data),
      .wr_req            (wr_req),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_ready          (wr_ready),
      .frame_end         (frame_end),
      .frame_done        (frame_done),
      .wbuf_count        (wbuf_count),
      .sram_read_enable  (sram_read_enable),
      .sram_write_enable (sram_write_enable),
      .sram_address      (sram_address),
      .sram_wdata        (sram_wdata),
      .sram_rdata        (sram_rdata)
   );

   always #5 clk = ~clk;

   assign outs = {rd_grant, wr_ready, rd_valid, rd_data, frame_done, wbuf_count,
                  sram_read_enable, sram_write_enable, sram_address, sram_wdata};

   function automatic logic [7:0] base_val(input logic [17:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ref_val(input logic [17:0] a);
      if (ref_mem.exists(int'(a)))
         return ref_mem[int'(a)];
      return base_val(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SRAM model: writes commit on the edge, read data presented mid-cycle.
   always @(posedge clk) begin
      cyc++;
      if (sram_write_enable)
         sram_mem[int'(sram_address)] = sram_wdata;
   end

   always @(negedge clk) begin
      if (sram_mem.exists(int'(sram_address)))
         sram_rdata = sram_mem[int'(sram_address)];
      else
         sram_rdata = base_val(sram_address);
   end

   always @(negedge clk) begin
      if (rd_valid) begin
         valid_cnt++;
         check("rd_pending", exp_rd.size() != 0, 1);
         if (exp_rd.size() != 0) begin
            check("rd_data", rd_data, exp_rd.pop_front());
            check("rd_latency", cyc, exp_rt.pop_front());
         end
      end
      if (sram_write_enable) begin
         last_we_cyc = cyc;
         check("wr_pending", exp_wr.size() != 0, 1);
         if (exp_wr.size() != 0)
            check("wr_op", {sram_address, sram_wdata}, exp_wr.pop_front());
      end
      if (sram_read_enable || sram_write_enable)
         check("strobe_excl", sram_read_enable && sram_write_enable, 0);
      if (frame_done) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
   end

   task automatic step(input logic rq, input logic [17:0] ra, input logic wq,
                       input logic [17:0] wa, input logic [7:0] wd, input logic fe,
                       output logic g, output logic r);
      rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd; frame_end = fe;
      @(negedge clk);
      g = rd_grant;
      r = wr_ready;
      if (wq && r) begin
         ref_mem[int'(wa)] = wd;
         exp_wr.push_back({wa, wd});
      end
      if (rq && g) begin
         exp_rd.push_back(ref_val(ra));
         exp_rt.push_back(cyc + 2);
      end
      @(posedge clk);
      #1;
      rd_req = 1'b0; wr_req = 1'b0; frame_end = 1'b0;
   endtask

   task automatic idle(input int n);
      logic g, r;
      repeat (n) step(1'b0, 18'h0, 1'b0, 18'h0, 8'h00, 1'b0, g, r);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic g, r;
      logic [7:0]  v2;
      logic [17:0] wa2 [6];
      logic [7:0]  wd2 [6];
      int k, widx, t3, t5, fd0, v0;

      // Reset state, with requests asserted to prove the handshakes are gated
      n_rst = 1'b0; rd_req = 1'b1; rd_addr = 18'h5; wr_req = 1'b1;
      wr_addr = 18'h5; wr_data = 8'hFF; frame_end = 1'b0;
      #12;
      check("reset_outputs", outs, 0);
      rd_req = 1'b0; wr_req = 1'b0;
      @(negedge clk) n_rst = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", wr_ready, 1);

      // 1: back-to-back reads
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 18'(i), 1'b0, 18'h0, 8'h00, 1'b0, g, r);
         check("t1_grant", g, 1);
      end
      idle(4);

      // 2: writes stalled behind continuous reads fill the buffer
      wa2 = '{FRAME_LAST_ADDR, 18'h10, 18'h11, 18'h12, 18'h13, 18'h14};
      wd2 = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
      v2 = 8'b1010_1111;
      k = 0; widx = 0;
      for (int s = 0; s < 8; s++) begin
         step(1'b1, 18'h100 + 18'(k), widx < 6, (widx < 6) ? wa2[widx] : 18'h0,
              (widx < 6) ? wd2[widx] : 8'h00, 1'b0, g, r);
         check("t2_grant", g, v2[s]);
         check("t2_ready", r, v2[s]);
         if (g) k++;
         if (r && widx < 6) widx++;
      end
      idle(8);
      check("t2_count_drained", wbuf_count, 0);

      // 3: one pending write must win after exactly MAX_RD_STREAK reads
      k = 0; t3 = cyc;
      for (int s = 0; s < 12; s++) begin
         step(1'b1, 18'h400 + 18'(k), s == 0, 18'h300, 8'h00, 1'b0, g, r);
         check("t3_grant", g, s != 9);
         if (g) k++;
      end
      idle(4);
      check("t3_write_cycle", last_we_cyc, t3 + 10);

      // 4: read of an address being written waits for the write
      step(1'b1, 18'h00200, 1'b1, 18'h00200, 8'hFF, 1'b0, g, r);
      check("t4_grant_c0", g, 0);
      check("t4_ready_c0", r, 1);
      step(1'b1, 18'h00200, 1'b0, 18'h0, 8'h00, 1'b0, g, r);
      check("t4_grant_c1", g, 0);
      step(1'b1, 18'h00200, 1'b0, 18'h0, 8'h00, 1'b0, g, r);
      check("t4_grant_c2", g, 1);
      idle(4);

      // 5: frame_end with three queued writes and a read in flight
      t5 = cyc; fd0 = fd_cnt;
      step(1'b1, 18'h500, 1'b1, 18'h600, 8'hFF, 1'b0, g, r);
      check("t5_grant_c0", g, 1);
      step(1'b1, 18'h501, 1'b1, 18'h601, 8'h00, 1'b0, g, r);
      check("t5_grant_c1", g, 1);
      step(1'b1, 18'h502, 1'b1, 18'h602, 8'hFF, 1'b0, g, r);
      check("t5_grant_c2", g, 1);
      check("t5_count", wbuf_count, 3);
      step(1'b1, 18'h503, 1'b0, 18'h0, 8'h00, 1'b1, g, r);
      check("t5_grant_flush", g, 0);
      for (int s = 4; s < 8; s++) begin
         step(1'b1, 18'h503, 1'b0, 18'h0, 8'h00, 1'b0, g, r);
         check("t5_grant_flush", g, 0);
      end
      step(1'b1, 18'h503, 1'b0, 18'h0, 8'h00, 1'b0, g, r);
      check("t5_grant_after_done", g, 1);
      idle(6);
      check("t5_done_pulses", fd_cnt - fd0, 1);
      check("t5_done_cycle", fd_cyc, t5 + 7);

      // 6: asynchronous reset with a full-ish buffer and a read in flight
      step(1'b1, 18'h510, 1'b1, 18'h700, 8'hFF, 1'b0, g, r);
      step(1'b1, 18'h511, 1'b1, 18'h701, 8'h00, 1'b0, g, r);
      step(1'b1, 18'h512, 1'b1, 18'h702, 8'hFF, 1'b0, g, r);
      check("t6_grant_before", g, 1);
      check("t6_count_before", wbuf_count, 3);
      rd_req = 1'b1; rd_addr = 18'h513; wr_req = 1'b1; wr_addr = 18'h703; wr_data = 8'h00;
      #1 n_rst = 1'b0;
      #1;
      check("t6_reset_outputs", outs, 0);
      exp_rd.delete(); exp_rt.delete(); exp_wr.delete();
      rd_req = 1'b0; wr_req = 1'b0;
      v0 = valid_cnt;
      @(negedge clk) n_rst = 1'b1;
      idle(6);
      check("t6_no_stray_valid", valid_cnt - v0, 0);
      check("t6_count_after", wbuf_count, 0);
      step(1'b1, 18'h520, 1'b0, 18'h0, 8'h00, 1'b0, g, r);
      check("t6_grant_after", g, 1);
      idle(4);

      check("queues_empty", exp_rd.size() + exp_wr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
